// File: rtl/seq_pkg.sv
// Shared types and helpers for the sequence-identifier serial path.
package seq_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} seq_ser_state_t;

    localparam int SEQ_DEFAULT_SIZE = 4;

    // Sizes below 2 still need a one-bit counter.
    function automatic int cnt_width(input int size);
        return (size < 2) ? 1 : $clog2(size);
    endfunction

endpackage

// File: rtl/seq_bit_counter.sv
// Modulo-SEQUENCE_SIZE bit counter with clear, increment and terminal-count flag.
module seq_bit_counter
    import seq_pkg::*;
#(
    parameter int SEQUENCE_SIZE = SEQ_DEFAULT_SIZE,
    localparam int CNT_W = cnt_width(SEQUENCE_SIZE)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap
);

    assign wrap = (cnt == CNT_W'(SEQUENCE_SIZE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= wrap ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seq_serializer.sv
// MSB-first parallel-to-serial transmitter with valid/ready load handshake.
// Optional trailing even-parity bit when SEQ_SERIALIZER_PARITY_EN is defined.
//
// state  | meaning
// IDLE   | no frame in flight, p_ready=1
// SHIFT  | data bits on s_out, counter tracks the bit index
// PARITY | parity bit on s_out (parity build only), p_ready=1
module seq_serializer
    import seq_pkg::*;
#(
    parameter int SEQUENCE_SIZE = SEQ_DEFAULT_SIZE
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [SEQUENCE_SIZE-1:0] p_in,
    input  logic                     p_valid,
    output logic                     p_ready,
    output logic                     s_out,
    output logic                     s_valid,
    output logic                     s_last
);

    localparam int CNT_W = cnt_width(SEQUENCE_SIZE);
`ifdef SEQ_SERIALIZER_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    seq_ser_state_t           state, state_d;
    logic [SEQUENCE_SIZE-1:0] sh, sh_d;
    logic                     s_out_d, s_valid_d, s_last_d;
    logic                     cnt_clr, cnt_inc, wrap, load;
    logic [CNT_W-1:0]         cnt;

    seq_bit_counter #(.SEQUENCE_SIZE(SEQUENCE_SIZE)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .cnt   (cnt),
        .wrap  (wrap)
    );

`ifdef SEQ_SERIALIZER_PARITY_EN
    logic par;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par <= 1'b0;
        end else if (load) begin
            par <= ^p_in;
        end
    end

    assign p_ready = (state == IDLE) || (state == PARITY);
`else
    assign p_ready = (state == IDLE) || ((state == SHIFT) && wrap);
`endif

    assign load = p_valid && p_ready;

    always_comb begin
        state_d   = state;
        sh_d      = sh;
        s_out_d   = 1'b0;
        s_valid_d = 1'b0;
        s_last_d  = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        // A load is only possible on an idle or final cycle, so it overrides the frame end.
        if (load) begin
            state_d   = SHIFT;
            sh_d      = {p_in[SEQUENCE_SIZE-2:0], 1'b0};
            s_out_d   = p_in[SEQUENCE_SIZE-1];
            s_valid_d = 1'b1;
            cnt_clr   = 1'b1;
        end else begin
            case (state)
                SHIFT: begin
                    cnt_inc = 1'b1;
                    if (!wrap) begin
                        sh_d      = {sh[SEQUENCE_SIZE-2:0], 1'b0};
                        s_out_d   = sh[SEQUENCE_SIZE-1];
                        s_valid_d = 1'b1;
                        s_last_d  = !PAR_EN && (cnt == CNT_W'(SEQUENCE_SIZE - 2));
                    end else begin
`ifdef SEQ_SERIALIZER_PARITY_EN
                        state_d   = PARITY;
                        s_out_d   = par;
                        s_valid_d = 1'b1;
                        s_last_d  = 1'b1;
`else
                        state_d   = IDLE;
`endif
                    end
                end
`ifdef SEQ_SERIALIZER_PARITY_EN
                PARITY: state_d = IDLE;
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sh      <= '0;
            s_out   <= 1'b0;
            s_valid <= 1'b0;
            s_last  <= 1'b0;
        end else begin
            state   <= state_d;
            sh      <= sh_d;
            s_out   <= s_out_d;
            s_valid <= s_valid_d;
            s_last  <= s_last_d;
        end
    end

endmodule

// File: tb/tb_seq_serializer.sv
// Self-checking bench for seq_serializer: directed scenarios plus random traffic
// against a queue-of-pending-bits reference model.
module tb_seq_serializer;

    localparam int N = 4;
`ifdef SEQ_SERIALIZER_PARITY_EN
    localparam int FRAME = N + 1;
`else
    localparam int FRAME = N;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         p_valid = 1'b0;
    logic [N-1:0] p_in = '0;
    logic         p_ready, s_out, s_valid, s_last;
    logic [N-1:0] rx = '0;

    int checks = 0;
    int errors = 0;

    // Bits still to appear on s_out; the front is the bit currently shown.
    bit exp_q[$];

    seq_serializer #(.SEQUENCE_SIZE(N)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .p_in    (p_in),
        .p_valid (p_valid),
        .p_ready (p_ready),
        .s_out   (s_out),
        .s_valid (s_valid),
        .s_last  (s_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (s_valid) rx <= {rx[N-2:0], s_out};
    end

    task automatic chk(input string tag, input string sig, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, sig, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        bit busy;
        busy = (exp_q.size() > 0);
        chk(tag, "s_valid", 32'(s_valid), 32'(busy));
        chk(tag, "s_out",   32'(s_out),   busy ? 32'(exp_q[0]) : 32'd0);
        chk(tag, "s_last",  32'(s_last),  32'(exp_q.size() == 1));
        chk(tag, "p_ready", 32'(p_ready), 32'(exp_q.size() <= 1));
    endtask

    task automatic push_frame(input logic [N-1:0] d);
        for (int i = N - 1; i >= 0; i--) exp_q.push_back(d[i]);
`ifdef SEQ_SERIALIZER_PARITY_EN
        exp_q.push_back(^d);
`endif
    endtask

    // Called just after a falling edge: drive, clock, update model, check.
    task automatic cycle(input bit v, input logic [N-1:0] d, input string tag);
        bit hs;
        p_valid = v;
        p_in    = d;
        hs      = v && (exp_q.size() <= 1);
        @(posedge clk);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (hs) push_frame(d);
        @(negedge clk);
        check_outputs(tag);
    endtask

    initial begin
        // Reset held with a pending request: nothing may load.
        rst_n   = 1'b0;
        p_valid = 1'b1;
        p_in    = 4'b1011;
        repeat (3) @(negedge clk);
        exp_q.delete();
        check_outputs("reset");
        rst_n   = 1'b1;
        p_valid = 1'b0;
        cycle(1'b0, 4'b0000, "post_reset");

        cycle(1'b1, 4'b1011, "single");
        repeat (FRAME) cycle(1'b0, 4'b0000, "single");
`ifndef SEQ_SERIALIZER_PARITY_EN
        chk("single", "loopback", 32'(rx), 32'(4'b1011));
`endif

        cycle(1'b1, 4'b1100, "b2b");
        repeat (FRAME) cycle(1'b1, 4'b0011, "b2b");
        repeat (FRAME + 1) cycle(1'b0, 4'b0000, "b2b");

        cycle(1'b1, 4'b1010, "bp");
        repeat (FRAME - 2) cycle(1'b1, 4'hF, "bp");
        repeat (FRAME + 1) cycle(1'b0, 4'hF, "bp");

        cycle(1'b1, 4'b1111, "rst_mid");
        cycle(1'b0, 4'b0000, "rst_mid");
        cycle(1'b0, 4'b0000, "rst_mid");
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        check_outputs("rst_mid_abort");
        @(negedge clk);
        rst_n = 1'b1;
        check_outputs("rst_mid_release");
        cycle(1'b1, 4'b0001, "rst_mid_next");
        repeat (FRAME) cycle(1'b0, 4'b0000, "rst_mid_next");
`ifndef SEQ_SERIALIZER_PARITY_EN
        chk("rst_mid_next", "loopback", 32'(rx), 32'(4'b0001));
`endif

`ifdef SEQ_SERIALIZER_PARITY_EN
        cycle(1'b1, 4'b0111, "par_odd");
        repeat (FRAME) cycle(1'b0, 4'b0000, "par_odd");
        cycle(1'b1, 4'b0110, "par_even");
        repeat (FRAME) cycle(1'b0, 4'b0000, "par_even");
`endif

        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, N'($urandom), "random");
        end
        repeat (FRAME + 1) cycle(1'b0, 4'b0000, "drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
